// File: rtl/adder_arbiter.sv
// adder_arbiter: round-robin arbiter that time-shares one external
// combinational adder between N_REQ requesters. One operation is in flight
// at a time: IDLE (grant) -> EXEC (adder settles) -> RESP (hold result).
module adder_arbiter #(
  parameter int NB_DATA = 32,
  parameter int N_REQ   = 4,
  parameter int NB_ID   = 2
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [N_REQ-1:0]         i_req_valid,
  input  logic [N_REQ*NB_DATA-1:0] i_req_a,
  input  logic [N_REQ*NB_DATA-1:0] i_req_b,
  output logic [N_REQ-1:0]         o_req_ready,
  output logic [NB_DATA-1:0]       o_adder_a,
  output logic [NB_DATA-1:0]       o_adder_b,
  input  logic [NB_DATA-1:0]       i_adder,
  output logic                     o_rsp_valid,
  output logic [NB_ID-1:0]         o_rsp_id,
  output logic [NB_DATA-1:0]       o_rsp_sum,
  input  logic                     i_rsp_ready
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [NB_ID-1:0]     last_q, last_d;
  logic [NB_ID-1:0]     rsp_id_q, rsp_id_d;
  logic [NB_DATA-1:0]   adder_a_q, adder_a_d;
  logic [NB_DATA-1:0]   adder_b_q, adder_b_d;
  logic [NB_DATA-1:0]   rsp_sum_q, rsp_sum_d;
  logic                 rsp_valid_q, rsp_valid_d;

  logic [N_REQ-1:0]     grant;
  logic [NB_ID-1:0]     gnt_idx;
  logic [NB_DATA-1:0]   req_a_arr [N_REQ];
  logic [NB_DATA-1:0]   req_b_arr [N_REQ];

  // Unpack the flat operand buses so a requester index selects a whole word.
  for (genvar k = 0; k < N_REQ; k++) begin : g_unpack
    assign req_a_arr[k] = i_req_a[k*NB_DATA +: NB_DATA];
    assign req_b_arr[k] = i_req_b[k*NB_DATA +: NB_DATA];
  end

  // Round-robin grant: first valid requester after the last one served.
  always_comb begin
    logic found;
    int   cand;
    // NOTE: every always_comb output gets a default first; a path that leaves
    // a signal unassigned would otherwise infer a latch.
    grant   = '0;
    gnt_idx = '0;
    found   = 1'b0;
    cand    = 0;
    if (state_q == IDLE) begin
      for (int i = 1; i <= N_REQ; i++) begin
        cand = (int'(last_q) + i) % N_REQ;
        if (!found && i_req_valid[NB_ID'(cand)]) begin
          found                = 1'b1;
          gnt_idx              = NB_ID'(cand);
          grant[NB_ID'(cand)]  = 1'b1;
        end
      end
    end
  end

  // Next-state and datapath register updates for the three-phase sequence.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    rsp_id_d    = rsp_id_q;
    adder_a_d   = adder_a_q;
    adder_b_d   = adder_b_q;
    rsp_sum_d   = rsp_sum_q;
    rsp_valid_d = rsp_valid_q;
    unique case (state_q)
      IDLE: begin
        // grant only ever marks a valid requester, so any grant is a handshake
        if (|grant) begin
          adder_a_d = req_a_arr[gnt_idx];
          adder_b_d = req_b_arr[gnt_idx];
          rsp_id_d  = gnt_idx;
          last_d    = gnt_idx;
          state_d   = EXEC;
        end
      end
      EXEC: begin
        rsp_sum_d   = i_adder;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (i_rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset points the round-robin at the last requester.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all flops
    // update together from pre-edge values, independent of statement order.
    if (!i_rst_n) begin
      state_q     <= IDLE;
      last_q      <= NB_ID'(N_REQ - 1);
      rsp_id_q    <= '0;
      adder_a_q   <= '0;
      adder_b_q   <= '0;
      rsp_sum_q   <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      rsp_id_q    <= rsp_id_d;
      adder_a_q   <= adder_a_d;
      adder_b_q   <= adder_b_d;
      rsp_sum_q   <= rsp_sum_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign o_req_ready = grant;
  assign o_adder_a   = adder_a_q;
  assign o_adder_b   = adder_b_q;
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_id    = rsp_id_q;
  assign o_rsp_sum   = rsp_sum_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// tb_adder_arbiter: scoreboard bench for adder_arbiter. The bench models the
// round-robin pointer and the adder sum, pushes the expected response when a
// grant is expected, and pops/compares when the DUT raises o_rsp_valid.
module tb_adder_arbiter;

  localparam int NB_DATA = 32;
  localparam int N_REQ   = 4;
  localparam int NB_ID   = 2;

  typedef struct {
    int          id;
    logic [31:0] sum;
  } exp_t;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic [N_REQ-1:0]         req_valid;
  logic [31:0]              op_a [N_REQ];
  logic [31:0]              op_b [N_REQ];
  logic [N_REQ*NB_DATA-1:0] req_a, req_b;
  logic [N_REQ-1:0]         o_req_ready;
  logic [NB_DATA-1:0]       o_adder_a, o_adder_b, adder_sum;
  logic                     o_rsp_valid;
  logic [NB_ID-1:0]         o_rsp_id;
  logic [NB_DATA-1:0]       o_rsp_sum;
  logic                     rsp_ready;

  int   checks = 0;
  int   errors = 0;
  int   model_last;
  exp_t sb[$];

  always #5 clk = ~clk;

  assign req_a     = {op_a[3], op_a[2], op_a[1], op_a[0]};
  assign req_b     = {op_b[3], op_b[2], op_b[1], op_b[0]};
  // the external shared adder
  assign adder_sum = o_adder_a + o_adder_b;

  adder_arbiter #(.NB_DATA(NB_DATA), .N_REQ(N_REQ), .NB_ID(NB_ID)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_req_valid (req_valid),
    .i_req_a     (req_a),
    .i_req_b     (req_b),
    .o_req_ready (o_req_ready),
    .o_adder_a   (o_adder_a),
    .o_adder_b   (o_adder_b),
    .i_adder     (adder_sum),
    .o_rsp_valid (o_rsp_valid),
    .o_rsp_id    (o_rsp_id),
    .o_rsp_sum   (o_rsp_sum),
    .i_rsp_ready (rsp_ready)
  );

  function automatic int rr_pick(input logic [3:0] v, input int last);
    for (int i = 1; i <= N_REQ; i++) begin
      if (v[(last + i) % N_REQ]) return (last + i) % N_REQ;
    end
    return -1;
  endfunction

  function automatic logic [3:0] onehot(input int k);
    return 4'(1) << k;
  endfunction

  task automatic wait_rsp(output bit got);
    got = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (o_rsp_valid === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_reset();
    req_valid = '0;
    rsp_ready = 1'b0;
    rst_n     = 1'b0;
    repeat (2) @(negedge clk);
    rst_n      = 1'b1;
    model_last = N_REQ - 1;
  endtask

  task automatic test_reset();
    for (int k = 0; k < N_REQ; k++) begin
      op_a[k] = '0;
      op_b[k] = '0;
    end
    req_valid = '0;
    rsp_ready = 1'b0;
    rst_n     = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (o_rsp_valid !== 1'b0 || o_rsp_sum !== '0 || o_rsp_id !== '0) begin
      errors++;
      $display("FAIL reset_rsp: valid=%b sum=%h id=%0d, want 0/0/0", o_rsp_valid, o_rsp_sum, o_rsp_id);
    end
    checks++;
    if (o_adder_a !== '0 || o_adder_b !== '0 || o_req_ready !== '0) begin
      errors++;
      $display("FAIL reset_operands: a=%h b=%h ready=%b, want 0/0/0", o_adder_a, o_adder_b, o_req_ready);
    end
    rst_n      = 1'b1;
    model_last = N_REQ - 1;
  endtask

  task automatic test_single();
    bit   got;
    exp_t e;
    op_a[2] = 32'd5;
    op_b[2] = 32'd7;
    req_valid = 4'b0100;
    rsp_ready = 1'b1;
    #1;
    checks++;
    if (o_req_ready !== 4'b0100) begin
      errors++;
      $display("FAIL single_grant: ready=%b want 0100", o_req_ready);
    end
    sb.push_back('{2, op_a[2] + op_b[2]});
    model_last = 2;
    @(negedge clk);
    req_valid = '0;
    checks++;
    if (o_rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_exec_valid: valid=%b want 0", o_rsp_valid);
    end
    @(negedge clk);
    checks++;
    if (o_rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL single_latency: valid=%b want 1 at T+1", o_rsp_valid);
    end else begin
      e = sb.pop_front();
      checks++;
      if (o_rsp_sum !== e.sum || o_rsp_id !== 2'(e.id)) begin
        errors++;
        $display("FAIL single_rsp: sum=%0d id=%0d want sum=%0d id=%0d", o_rsp_sum, o_rsp_id, e.sum, e.id);
      end
    end
    @(negedge clk);
    checks++;
    if (o_rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_idle: valid=%b want 0 at T+2", o_rsp_valid);
    end
    sb.delete();
  endtask

  // Shared body for the continuous-request scenarios; comparisons inline.
  task automatic run_stream(input string tag, input logic [3:0] v, input int n_ops);
    bit         got;
    exp_t       e;
    int         k;
    logic [3:0] prev = '0;
    req_valid = v;
    rsp_ready = 1'b1;
    for (int n = 0; n < n_ops; n++) begin
      #1;
      k = rr_pick(v, model_last);
      checks++;
      if (o_req_ready !== onehot(k)) begin
        errors++;
        $display("FAIL %s_grant%0d: ready=%b want %b", tag, n, o_req_ready, onehot(k));
      end
      checks++;
      if (o_req_ready === prev) begin
        errors++;
        $display("FAIL %s_repeat%0d: ready=%b same as previous grant", tag, n, o_req_ready);
      end
      prev = o_req_ready;
      sb.push_back('{k, op_a[k] + op_b[k]});
      model_last = k;
      wait_rsp(got);
      checks++;
      if (!got) begin
        errors++;
        $display("FAIL %s_timeout%0d: no response, want one", tag, n);
        sb.delete();
      end else begin
        e = sb.pop_front();
        checks++;
        if (o_rsp_sum !== e.sum || o_rsp_id !== 2'(e.id)) begin
          errors++;
          $display("FAIL %s_rsp%0d: sum=%h id=%0d want sum=%h id=%0d", tag, n, o_rsp_sum, o_rsp_id, e.sum, e.id);
        end
      end
      @(negedge clk);
    end
    req_valid = '0;
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int k = 0; k < N_REQ; k++) begin
      op_a[k] = 32'h1000 * (k + 1) + 32'(k);
      op_b[k] = 32'h0011 * (k + 3);
    end
    run_stream("rr", 4'b1111, 5);
  endtask

  task automatic test_pair();
    do_reset();
    op_a[0] = 32'hDEAD_0000; op_b[0] = 32'h0000_BEEF;
    op_a[3] = 32'h7FFF_FFF0; op_b[3] = 32'h0000_0020;
    run_stream("pair", 4'b1001, 4);
  endtask

  task automatic test_hold();
    bit          got;
    exp_t        e;
    logic [31:0] held_sum;
    logic [1:0]  held_id;
    op_a[1] = 32'd100;
    op_b[1] = 32'd23;
    req_valid = 4'b0010;
    rsp_ready = 1'b0;
    #1;
    checks++;
    if (o_req_ready !== 4'b0010) begin
      errors++;
      $display("FAIL hold_grant: ready=%b want 0010", o_req_ready);
    end
    sb.push_back('{1, op_a[1] + op_b[1]});
    model_last = 1;
    wait_rsp(got);
    req_valid = '0;
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL hold_timeout: no response, want one");
      sb.delete();
    end else begin
      e = sb.pop_front();
      checks++;
      if (o_rsp_sum !== e.sum || o_rsp_id !== 2'(e.id)) begin
        errors++;
        $display("FAIL hold_rsp: sum=%0d id=%0d want sum=%0d id=%0d", o_rsp_sum, o_rsp_id, e.sum, e.id);
      end
      held_sum = e.sum;
      held_id  = 2'(e.id);
      for (int c = 0; c < 5; c++) begin
        @(negedge clk);
        checks++;
        if (o_rsp_valid !== 1'b1 || o_rsp_sum !== held_sum || o_rsp_id !== held_id || o_req_ready !== '0) begin
          errors++;
          $display("FAIL hold_stable%0d: valid=%b sum=%0d id=%0d ready=%b want 1/%0d/%0d/0000",
                   c, o_rsp_valid, o_rsp_sum, o_rsp_id, o_req_ready, held_sum, held_id);
        end
      end
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (o_rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL hold_release: valid=%b want 0", o_rsp_valid);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] va [2] = '{32'hFFFF_FFFF, 32'h8000_0000};
    logic [31:0] vb [2] = '{32'h0000_0001, 32'h8000_0000};
    for (int i = 0; i < 2; i++) begin
      op_a[0] = va[i];
      op_b[0] = vb[i];
      run_stream($sformatf("wrap%0d", i), 4'b0001, 1);
      checks++;
      if (o_adder_a !== va[i] || o_adder_b !== vb[i]) begin
        errors++;
        $display("FAIL wrap%0d_operands: a=%h b=%h want a=%h b=%h", i, o_adder_a, o_adder_b, va[i], vb[i]);
      end
    end
  endtask

  task automatic test_reset_mid_exec();
    op_a[1] = 32'd10;
    op_b[1] = 32'd20;
    req_valid = 4'b0010;
    rsp_ready = 1'b1;
    @(posedge clk);
    #2;
    req_valid = '0;
    rst_n = 1'b0;
    #1;
    checks++;
    if (o_rsp_valid !== 1'b0 || o_rsp_sum !== '0 || o_rsp_id !== '0 ||
        o_adder_a !== '0 || o_adder_b !== '0 || o_req_ready !== '0) begin
      errors++;
      $display("FAIL midexec_reset: valid=%b sum=%h id=%0d a=%h b=%h ready=%b want all 0",
               o_rsp_valid, o_rsp_sum, o_rsp_id, o_adder_a, o_adder_b, o_req_ready);
    end
    @(negedge clk);
    rst_n      = 1'b1;
    model_last = N_REQ - 1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if (o_rsp_valid !== 1'b0) begin
        errors++;
        $display("FAIL midexec_ghost%0d: valid=%b want 0", c, o_rsp_valid);
      end
    end
    run_stream("restart", 4'b1111, 2);
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_pair();
    test_hold();
    test_wrap();
    test_reset_mid_exec();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
